// File: rtl/psk_tx_pkg.sv
// Shared types and constants for the PSK transmit framer: FSM encoding,
// symbols-per-byte counts and the CRC-8 update used when the CRC trailer is built.
package psk_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_SYNC = 3'd2,
      ST_HDR  = 3'd3,
      ST_PAY  = 3'd4,
      ST_CRC  = 3'd5
   } state_t;

   localparam int SYM_PER_BYTE_BPSK = 8;
   localparam int SYM_PER_BYTE_QPSK = 4;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   // One whole byte through the MSB-first CRC-8 register.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/psk_sym_serializer.sv
// Byte shift register that hands out 1-bit (BPSK) or 2-bit (QPSK) symbols MSB first.
// On load the first symbol is returned combinationally so the caller can emit it at once.
module psk_sym_serializer
   import psk_tx_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic       i_shift,
   input  logic       i_qpsk,
   input  logic [7:0] i_byte,
   output logic [1:0] o_first_sym,
   output logic [1:0] o_sym,
   output logic       o_empty,
   output logic       o_last
);

   logic [7:0] r_sr;
   logic [2:0] r_cnt;
   logic       r_qpsk;

   // r_cnt counts the symbols still held after the one already handed out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_qpsk <= 1'b0;
      end else if (i_load) begin
         r_qpsk <= i_qpsk;
         r_sr   <= i_qpsk ? {i_byte[5:0], 2'b00} : {i_byte[6:0], 1'b0};
         r_cnt  <= i_qpsk ? 3'(SYM_PER_BYTE_QPSK - 1) : 3'(SYM_PER_BYTE_BPSK - 1);
      end else if (i_shift && (r_cnt != 3'd0)) begin
         r_sr  <= r_qpsk ? {r_sr[5:0], 2'b00} : {r_sr[6:0], 1'b0};
         r_cnt <= r_cnt - 3'd1;
      end
   end

   assign o_first_sym = i_qpsk ? i_byte[7:6] : {2{i_byte[7]}};
   assign o_sym       = r_qpsk ? r_sr[7:6]   : {2{r_sr[7]}};
   assign o_empty     = (r_cnt == 3'd0);
   assign o_last      = (r_cnt == 3'd1);

endmodule

// File: rtl/psk_tx_framer.sv
// Frame scheduler feeding the BPSK/QPSK modulator: preamble, sync, header, payload.
// Define PSK_TX_FRAMER_CRC_EN to append a CRC-8 byte after the payload.
module psk_tx_framer
   import psk_tx_pkg::*;
#(
   parameter int         BYTES     = 1,
   parameter int         PRE_LEN   = 32,
   parameter logic [7:0] SYNC_WORD = 8'hA7
) (
   input  logic               clk_16M384,
   input  logic               rst_16M384_n,
   input  logic [7:0]         s_tdata,
   input  logic               s_tvalid,
   output logic               s_tready,
   input  logic               s_tlast,
   input  logic               cfg_qpsk,
   output logic [BYTES*8-1:0] m_tdata,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               m_tlast,
   output logic               m_tuser,
   output logic               busy,
   output logic               underrun,
   output logic [15:0]        frame_cnt
);

   state_t      r_state, w_state_nxt;
   logic        r_mode;
   logic [6:0]  r_seq;
   logic [7:0]  r_cnt;
   logic        r_last_byte;
   logic        r_stall;
   logic        r_underrun;
   logic [15:0] r_frame_cnt;
   logic        r_m_tvalid, r_m_tlast, r_m_tuser;
   logic [1:0]  r_m_sym;
`ifdef PSK_TX_FRAMER_CRC_EN
   logic [7:0]  r_crc;
`endif

   logic       w_load_ok, w_fin, w_load, w_bpsk, w_tlast, w_accept, w_stall;
   logic       w_ser_load, w_ser_shift, w_ser_empty, w_ser_last, w_cnt_clr, w_cnt_inc, w_s_tready;
   logic [1:0] w_sym, w_ser_sym, w_ser_first;
   logic [7:0] w_ser_byte, w_hdr;

   assign w_load_ok = !r_m_tvalid || m_tready;
   assign w_fin     = r_m_tvalid && m_tready && r_m_tlast;
   assign w_hdr     = {r_mode, r_seq};

   psk_sym_serializer u_ser (
      .clk         (clk_16M384),
      .rst_n       (rst_16M384_n),
      .i_load      (w_ser_load),
      .i_shift     (w_ser_shift),
      .i_qpsk      (r_mode),
      .i_byte      (w_ser_byte),
      .o_first_sym (w_ser_first),
      .o_sym       (w_ser_sym),
      .o_empty     (w_ser_empty),
      .o_last      (w_ser_last)
   );

   always_ff @(posedge clk_16M384 or negedge rst_16M384_n) begin
      if (!rst_16M384_n) r_state <= ST_IDLE;
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      else               r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_sym       = 2'b00;
      w_bpsk      = 1'b1;
      w_tlast     = 1'b0;
      w_ser_load  = 1'b0;
      w_ser_shift = 1'b0;
      w_ser_byte  = s_tdata;
      w_accept    = 1'b0;
      w_s_tready  = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (s_tvalid) begin
               w_state_nxt = ST_PRE;
               w_cnt_clr   = 1'b1;
            end
         end
         ST_PRE: begin
            if (w_load_ok) begin
               w_load = 1'b1;
               w_sym  = {2{~r_cnt[0]}};
               if (r_cnt == 8'(PRE_LEN - 1)) begin
                  w_state_nxt = ST_SYNC;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         ST_SYNC, ST_HDR: begin
            if (w_load_ok) begin
               w_load = 1'b1;
               // Bit index 7-n equals ~n on three bits: MSB first.
               w_sym  = (r_state == ST_SYNC) ? {2{SYNC_WORD[~r_cnt[2:0]]}} : {2{w_hdr[~r_cnt[2:0]]}};
               if (r_cnt[2:0] == 3'd7) begin
                  w_state_nxt = (r_state == ST_SYNC) ? ST_HDR : ST_PAY;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         ST_PAY: begin
            w_bpsk = ~r_mode;
            if (!w_ser_empty) begin
               if (w_load_ok) begin
                  w_load      = 1'b1;
                  w_sym       = w_ser_sym;
                  w_ser_shift = 1'b1;
`ifndef PSK_TX_FRAMER_CRC_EN
                  w_tlast     = w_ser_last & r_last_byte;
`endif
               end
            end else if (!r_last_byte) begin
               w_s_tready = w_load_ok;
               if (!s_tvalid) begin
                  w_stall = 1'b1;
               end else if (w_load_ok) begin
                  w_accept   = 1'b1;
                  w_ser_load = 1'b1;
                  w_load     = 1'b1;
                  w_sym      = w_ser_first;
               end
            end else begin
`ifdef PSK_TX_FRAMER_CRC_EN
               if (w_load_ok) begin
                  w_ser_byte  = r_crc;
                  w_ser_load  = 1'b1;
                  w_load      = 1'b1;
                  w_sym       = w_ser_first;
                  w_state_nxt = ST_CRC;
               end
`else
               if (w_fin) w_state_nxt = ST_IDLE;
`endif
            end
         end
`ifdef PSK_TX_FRAMER_CRC_EN
         ST_CRC: begin
            w_bpsk = ~r_mode;
            if (!w_ser_empty) begin
               if (w_load_ok) begin
                  w_load      = 1'b1;
                  w_sym       = w_ser_sym;
                  w_ser_shift = 1'b1;
                  w_tlast     = w_ser_last;
               end
            end else if (w_fin) begin
               w_state_nxt = ST_IDLE;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_16M384 or negedge rst_16M384_n) begin
      if (!rst_16M384_n) begin
         r_mode      <= 1'b0;
         r_seq       <= '0;
         r_cnt       <= '0;
         r_last_byte <= 1'b0;
         r_frame_cnt <= '0;
         r_stall     <= 1'b0;
         r_underrun  <= 1'b0;
`ifdef PSK_TX_FRAMER_CRC_EN
         r_crc       <= '0;
`endif
      end else begin
         if (r_state == ST_IDLE && s_tvalid) begin
            r_mode      <= cfg_qpsk;
            r_last_byte <= 1'b0;
`ifdef PSK_TX_FRAMER_CRC_EN
            r_crc       <= '0;
`endif
         end
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
         if (w_accept) begin
            r_last_byte <= s_tlast;
`ifdef PSK_TX_FRAMER_CRC_EN
            r_crc       <= crc8_update(r_crc, s_tdata);
`endif
         end
         if (w_fin) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_seq       <= r_seq + 7'd1;
         end
         // One pulse on the first cycle of each stall episode.
         r_stall    <= w_stall;
         r_underrun <= w_stall & ~r_stall;
      end
   end

   // Output slot: refilled only when empty or being consumed, zeroed when nothing to send.
   always_ff @(posedge clk_16M384 or negedge rst_16M384_n) begin
      if (!rst_16M384_n) begin
         r_m_tvalid <= 1'b0;
         r_m_sym    <= '0;
         r_m_tlast  <= 1'b0;
         r_m_tuser  <= 1'b0;
      end else if (w_load_ok) begin
         r_m_tvalid <= w_load;
         r_m_sym    <= w_sym;
         r_m_tlast  <= w_tlast;
         r_m_tuser  <= w_load & w_bpsk;
      end
   end

   assign s_tready  = w_s_tready;
   assign m_tdata   = {{(BYTES*8-2){1'b0}}, r_m_sym};
   assign m_tvalid  = r_m_tvalid;
   assign m_tlast   = r_m_tlast;
   assign m_tuser   = r_m_tuser;
   assign busy      = (r_state != ST_IDLE);
   assign underrun  = r_underrun;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_psk_tx_framer.sv
// Self-checking bench for psk_tx_framer: a frame-level symbol model is compared
// against every accepted output symbol, plus literal expectations for fixed frames.
`timescale 1ns/1ps
module tb_psk_tx_framer;

   localparam int         PRE_LEN = 32;
   localparam logic [7:0] SYNC    = 8'hA7;
`ifdef PSK_TX_FRAMER_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   typedef struct packed {
      logic       last;
      logic       user;
      logic [1:0] sym;
   } sym_t;

   logic        clk = 1'b0;
   logic        rst_16M384_n;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic        cfg_qpsk;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic        m_tuser;
   logic        busy;
   logic        underrun;
   logic [15:0] frame_cnt;

   sym_t exp_q[$];
   sym_t cap_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_underrun = 0;
   int   model_seq = 0;
   int   model_frames = 0;
   bit   rnd_ready = 1'b0;
   bit   rnd_gap = 1'b0;
   bit   hold = 1'b0;
   logic [9:0] held;

   always #5 clk = ~clk;

   psk_tx_framer #(.BYTES(1), .PRE_LEN(PRE_LEN), .SYNC_WORD(SYNC)) dut (
      .clk_16M384   (clk),
      .rst_16M384_n (rst_16M384_n),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .s_tlast      (s_tlast),
      .cfg_qpsk     (cfg_qpsk),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready),
      .m_tlast      (m_tlast),
      .m_tuser      (m_tuser),
      .busy         (busy),
      .underrun     (underrun),
      .frame_cnt    (frame_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] ref_crc(input logic [7:0] bytes[$]);
      logic [7:0] crc = 8'h00;
      logic       fb;
      foreach (bytes[i]) begin
         for (int k = 7; k >= 0; k--) begin
            fb  = crc[7] ^ bytes[i][k];
            crc = {crc[6:0], 1'b0};
            if (fb) crc = crc ^ 8'h07;
         end
      end
      return crc;
   endfunction

   task automatic push_byte(input bit qpsk, input logic [7:0] b);
      sym_t s;
      if (qpsk) begin
         for (int k = 3; k >= 0; k--) begin
            s = '{last: 1'b0, user: 1'b0, sym: 2'((b >> (2 * k)) & 8'h03)};
            exp_q.push_back(s);
         end
      end else begin
         for (int k = 7; k >= 0; k--) begin
            s = '{last: 1'b0, user: 1'b1, sym: {b[k], b[k]}};
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic model_frame(input bit qpsk, input logic [7:0] bytes[$]);
      sym_t s;
      logic [7:0] hdr;
      for (int i = 0; i < PRE_LEN; i++) begin
         s = '{last: 1'b0, user: 1'b1, sym: (i % 2 == 0) ? 2'd3 : 2'd0};
         exp_q.push_back(s);
      end
      push_byte(1'b0, SYNC);
      hdr = {qpsk, 7'(model_seq)};
      push_byte(1'b0, hdr);
      foreach (bytes[i]) push_byte(qpsk, bytes[i]);
      if (CRC_ON) push_byte(qpsk, ref_crc(bytes));
      exp_q[exp_q.size() - 1].last = 1'b1;
      model_seq    = (model_seq + 1) % 128;
      model_frames = model_frames + 1;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      sym_t cur, e;
      if (!rst_16M384_n) begin
         hold = 1'b0;
      end else begin
         if (underrun) n_underrun++;
         if (hold) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", {m_tlast, m_tuser, m_tdata}, held);
         end
         hold = m_tvalid && !m_tready;
         held = {m_tlast, m_tuser, m_tdata};
         if (m_tvalid && m_tready) begin
            cur = '{last: m_tlast, user: m_tuser, sym: m_tdata[1:0]};
            cap_q.push_back(cur);
            check("tdata_pad", m_tdata[7:2], 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_symbol: got %0h expected none at %0t", cur, $time);
            end else begin
               e = exp_q.pop_front();
               check("symbol", cur, e);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_byte(input logic [7:0] b, input bit last);
      bit acc = 1'b0;
      int n = 0;
      s_tdata  = b;
      s_tlast  = last;
      s_tvalid = 1'b1;
      do begin
         @(negedge clk);
         acc = s_tready;
         n++;
         @(posedge clk);
         #1;
      end while (!acc && n < 5000);
      if (!acc) check("byte_accept_timeout", n, 0);
   endtask

   task automatic wait_frame_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("frame_drained", exp_q.size(), 0);
      @(posedge clk);
      @(negedge clk);
      check("frame_cnt_model", frame_cnt, 16'(model_frames));
      check("busy_after_frame", busy, 0);
   endtask

   task automatic run_frame(input bit qpsk, input logic [7:0] bytes[$], input int gap_after,
                            input int gap_len, output int gap_idle);
      gap_idle = 0;
      cfg_qpsk = qpsk;
      cap_q.delete();
      model_frame(qpsk, bytes);
      foreach (bytes[i]) begin
         drive_byte(bytes[i], i == bytes.size() - 1);
         if (i == gap_after) begin
            s_tvalid = 1'b0;
            repeat (gap_len) begin
               @(negedge clk);
               if (!m_tvalid) gap_idle++;
            end
            @(posedge clk);
            #1;
         end else if (rnd_gap && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            cfg_qpsk = ~cfg_qpsk;
            repeat ($urandom_range(1, 12)) @(posedge clk);
            #1;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      wait_frame_done();
   endtask

   initial begin
      logic [7:0] bq[$];
      logic [1:0] pay1 [8];
      logic [1:0] pay2 [8];
      logic [1:0] hdr2 [8];
      logic [1:0] crc6 [8];
      int gi, u0, n, users, hb;

      pay1 = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
      pay2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      hdr2 = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
      crc6 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};

      s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; cfg_qpsk = 1'b0;
      rst_16M384_n = 1'b0;
      #2;
      check("rst_tvalid", m_tvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_outputs", {m_tdata, m_tlast, m_tuser, underrun, s_tready}, 0);
      repeat (3) @(negedge clk);
      rst_16M384_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: single BPSK byte
      u0 = n_underrun;
      bq = {8'hC3};
      run_frame(1'b0, bq, -1, 0, gi);
      check("t1_len", cap_q.size(), 56 + (CRC_ON ? 8 : 0));
      users = 0;
      foreach (cap_q[i]) users += cap_q[i].user;
      check("t1_all_bpsk", users, cap_q.size());
      for (int i = 0; i < 8; i++) check("t1_payload", cap_q[48 + i].sym, pay1[i]);
      check("t1_tlast", cap_q[55].last, !CRC_ON);
      check("t1_frame_cnt", frame_cnt, 1);
      check("t1_no_underrun", n_underrun - u0, 0);

      // 2: QPSK two bytes, seq 1
      bq = {8'h1B, 8'hE4};
      run_frame(1'b1, bq, -1, 0, gi);
      check("t2_len", cap_q.size(), 56 + (CRC_ON ? 4 : 0));
      for (int i = 0; i < 8; i++) check("t2_header", cap_q[40 + i].sym, hdr2[i]);
      for (int i = 0; i < 8; i++) begin
         check("t2_payload", cap_q[48 + i].sym, pay2[i]);
         check("t2_qpsk_user", cap_q[48 + i].user, 0);
      end

      // 3: same as 1 under random back-pressure
      rnd_ready = 1'b1;
      bq = {8'hC3};
      run_frame(1'b0, bq, -1, 0, gi);
      check("t3_len", cap_q.size(), 56 + (CRC_ON ? 8 : 0));
      for (int i = 0; i < 8; i++) check("t3_payload", cap_q[48 + i].sym, pay1[i]);
      rnd_ready = 1'b0;
      @(posedge clk);
      #1;

      // 4: ten-cycle payload gap
      u0 = n_underrun;
      bq = {8'h5A, 8'h3C};
      run_frame(1'b0, bq, 0, 10, gi);
      check("t4_one_underrun", n_underrun - u0, 1);
      check("t4_gap_idle", gi > 0, 1);
      check("t4_len", cap_q.size(), 64 + (CRC_ON ? 8 : 0));

      // random frames: mode, length, back-pressure and source gaps
      rnd_ready = 1'b1;
      rnd_gap   = 1'b1;
      for (int f = 0; f < 6; f++) begin
         bq.delete();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
         run_frame(1'($urandom_range(0, 1)), bq, -1, 0, gi);
      end
      rnd_ready = 1'b0;
      rnd_gap   = 1'b0;
      @(posedge clk);
      #1;

      // 5: reset while the header is going out
      cfg_qpsk = 1'b0;
      cap_q.delete();
      bq = {8'h77};
      model_frame(1'b0, bq);
      s_tdata = 8'h77; s_tlast = 1'b1; s_tvalid = 1'b1;
      n = 0;
      while (cap_q.size() < PRE_LEN + 8 + 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t5_reached_hdr", cap_q.size() >= PRE_LEN + 8 + 2, 1);
      #2;
      rst_16M384_n = 1'b0;
      #1;
      check("t5_rst_tvalid", m_tvalid, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_outputs", {m_tdata, m_tlast, m_tuser, underrun, s_tready}, 0);
      check("t5_rst_frame_cnt", frame_cnt, 0);
      exp_q.delete();
      model_seq = 0;
      model_frames = 0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      @(negedge clk);
      rst_16M384_n = 1'b1;
      @(posedge clk);
      #1;
      bq = {8'hA5};
      run_frame(1'b0, bq, -1, 0, gi);
      hb = 0;
      for (int i = 0; i < 8; i++) hb = hb | (int'(cap_q[40 + i].sym) << (2 * i));
      check("t5_hdr_seq0", hb, 0);
      check("t5_pre_first", cap_q[0].sym, 3);
      check("t5_frame_cnt", frame_cnt, 1);

`ifdef PSK_TX_FRAMER_CRC_EN
      // 6: CRC trailer for payload 0x01 is 0x07
      bq = {8'h01};
      run_frame(1'b0, bq, -1, 0, gi);
      check("t6_len", cap_q.size(), 64);
      for (int i = 0; i < 8; i++) check("t6_crc", cap_q[56 + i].sym, crc6[i]);
      check("t6_tlast", cap_q[63].last, 1);
      check("t6_no_early_tlast", cap_q[55].last, 0);
`endif

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
